// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU pipeline stages.
package cpu_pkg;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_t;

    // Byte strobes at lane 0; shifted up by the byte lane for sub-word stores.
    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword from a bus word and sign- or zero-extends it.
module mem_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic        size_byte,
    input  logic        size_hwrd,
    input  logic        rdu,
    output logic [31:0] result
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        sel_b = rdata[7:0];
        case (lane)
            2'd0: sel_b = rdata[7:0];
            2'd1: sel_b = rdata[15:8];
            2'd2: sel_b = rdata[23:16];
            2'd3: sel_b = rdata[31:24];
            default: sel_b = rdata[7:0];
        endcase
        sel_h = lane[1] ? rdata[31:16] : rdata[15:0];

        if (size_byte) begin
            result = {{24{sel_b[7] & ~rdu}}, sel_b};
        end else if (size_hwrd) begin
            result = {{16{sel_h[15] & ~rdu}}, sel_h};
        end else begin
            result = rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: data-bus load/store handshake, load extension, writeback and branch redirect.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exec_mem_writeback,
    input  logic              exec_mem_link,
    input  logic              exec_mem_mem_w,
    input  logic              exec_mem_mem_r,
    input  logic              exec_mem_mem_rdu,
    input  logic              exec_mem_mem_byte,
    input  logic              exec_mem_mem_hwrd,
    input  logic              exec_mem_mem_wrd,
    input  logic [5:0]        exec_mem_rd,
    input  logic [31:0]       exec_mem_alu_result,
    input  logic [31:0]       exec_mem_mem_wdata,
    input  logic [31:0]       exec_mem_bta,
    input  logic              exec_mem_brnch_taken,
    output logic              mem_stall,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [31:0]       dbus_wdata,
    output logic [3:0]        dbus_wstrb,
    input  logic              dbus_ack,
    input  logic [31:0]       dbus_rdata,
    output logic              mem_wb_writeback,
    output logic [5:0]        mem_wb_rd,
    output logic [31:0]       mem_wb_result,
    output logic              mem_fetch_redirect,
    output logic [31:0]       mem_fetch_target,
    output logic              mem_misaligned
);

    mem_state_t        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              wb_q, wb_d;
    logic [5:0]        rd_q, rd_d;
    logic [31:0]       result_q, result_d;
    logic              redirect_q, redirect_d;
    logic [31:0]       target_q, target_d;
    logic              misal_q, misal_d;

    logic [1:0]  lane;
    logic        is_mem, misal, access, retire;
    logic        idle, busy;
    logic [31:0] word_addr, load_data, st_data;
    logic [3:0]  st_strb;

    // exec_mem_link needs no handling here: execute already placed pc+4 on alu_result.
    assign lane      = exec_mem_alu_result[1:0];
    assign is_mem    = exec_mem_mem_r | exec_mem_mem_w;
    assign misal     = is_mem & ((exec_mem_mem_hwrd & lane[0]) | (exec_mem_mem_wrd & (lane != 2'd0)));
    assign access    = is_mem & ~misal;
    assign idle      = (state_q == MEM_IDLE);
    assign busy      = (state_q == MEM_BUSY);
    assign retire    = (idle & ~access) | (busy & dbus_ack);
    assign mem_stall = (idle & access) | (busy & ~dbus_ack);
    assign word_addr = {exec_mem_alu_result[31:2], 2'b00};

    mem_load_align u_load_align (
        .rdata     (dbus_rdata),
        .lane      (lane),
        .size_byte (exec_mem_mem_byte),
        .size_hwrd (exec_mem_mem_hwrd),
        .rdu       (exec_mem_mem_rdu),
        .result    (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MEM_IDLE: if (access) state_d = MEM_BUSY;
            MEM_BUSY: if (dbus_ack) state_d = MEM_IDLE;
            default:  state_d = MEM_IDLE;
        endcase
    end

    always_comb begin
        if (exec_mem_mem_byte) begin
            st_strb = STRB_B << lane;
            st_data = {4{exec_mem_mem_wdata[7:0]}};
        end else if (exec_mem_mem_hwrd) begin
            st_strb = STRB_H << lane;
            st_data = {2{exec_mem_mem_wdata[15:0]}};
        end else begin
            st_strb = STRB_W;
            st_data = exec_mem_mem_wdata;
        end
    end

    // Bus outputs are only loaded on issue, so they stay frozen for the whole BUSY phase.
    always_comb begin
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wb_d       = 1'b0;
        rd_d       = rd_q;
        result_d   = result_q;
        redirect_d = 1'b0;
        target_d   = target_q;
        misal_d    = 1'b0;

        if (idle && access) begin
            req_d   = 1'b1;
            we_d    = exec_mem_mem_w;
            addr_d  = word_addr[ADDR_W-1:0];
            wdata_d = exec_mem_mem_w ? st_data : 32'd0;
            wstrb_d = exec_mem_mem_w ? st_strb : 4'b0000;
        end
        if (busy && dbus_ack) begin
            req_d = 1'b0;
        end
        if (retire) begin
            wb_d       = exec_mem_writeback & ~exec_mem_mem_w & ~misal;
            rd_d       = exec_mem_rd;
            result_d   = exec_mem_mem_r ? load_data : exec_mem_alu_result;
            redirect_d = exec_mem_brnch_taken & ~misal;
            target_d   = exec_mem_bta;
            misal_d    = misal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'b0000;
            wb_q       <= 1'b0;
            rd_q       <= 6'd0;
            result_q   <= 32'd0;
            redirect_q <= 1'b0;
            target_q   <= 32'd0;
            misal_q    <= 1'b0;
        end else begin
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wb_q       <= wb_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
            misal_q    <= misal_d;
        end
    end

    assign dbus_req           = req_q;
    assign dbus_we            = we_q;
    assign dbus_addr          = addr_q;
    assign dbus_wdata         = wdata_q;
    assign dbus_wstrb         = wstrb_q;
    assign mem_wb_writeback   = wb_q;
    assign mem_wb_rd          = rd_q;
    assign mem_wb_result      = result_q;
    assign mem_fetch_redirect = redirect_q;
    assign mem_fetch_target   = target_q;
    assign mem_misaligned     = misal_q;

endmodule
